mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory between two requesters: data-cache refill/writeback (port D) and instruction fetch (port I).
- Sits between the cache/fetch front ends and main memory.
- Sequences each access over a fixed memory latency with a small FSM.
- Arbitrates simultaneous requests round-robin and returns stall to the requesters until their access completes.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (D and I ports) and memory-side signals of the shared memory arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    input  i_req, i_we, i_addr, i_wdata,
    input  mem_rd,
    output d_ack, d_rdata, d_stall,
    output i_ack, i_rdata, i_stall,
    output mem_en, mem_we, mem_addr, mem_wd
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    output i_req, i_we, i_addr, i_wdata,
    output mem_rd,
    input  d_ack, d_rdata, d_stall,
    input  i_ack, i_rdata, i_stall,
    input  mem_en, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between a data port (D) and an
// instruction-fetch port (I); each access runs IDLE -> BUSY (LATENCY cycles) -> DONE (ack).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Port select encoding: 0 = D, 1 = I.
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              pick;

  // On a conflict the port that was not served last wins.
  assign pick = (bus.d_req && bus.i_req) ? ~last_q : bus.i_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.d_req || bus.i_req) begin
          grant_d = pick;
          last_d  = pick;
          we_d    = pick ? bus.i_we    : bus.d_we;
          addr_d  = pick ? bus.i_addr  : bus.d_addr;
          wd_d    = pick ? bus.i_wdata : bus.d_wdata;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!we_q) begin
            if (grant_q) i_rdata_d = bus.mem_rd;
            else         d_rdata_d = bus.mem_rd;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  assign bus.mem_en   = (state_q == StBusy);
  assign bus.mem_we   = (state_q == StBusy) && we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wd_q;
  assign bus.d_ack    = (state_q == StDone) && !grant_q;
  assign bus.i_ack    = (state_q == StDone) && grant_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_stall  = bus.d_req && !bus.d_ack;
  assign bus.i_stall  = bus.i_req && !bus.i_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (LATENCY 4 and 1) share one random stimulus stream and are
// compared every cycle against a timestamp-based model, plus hand-computed directed checks.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          d_req, d_we, i_req, i_we;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata, i_wdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 10'h010) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.d_req = d_req;  assign bus1.d_req = d_req;
  assign bus0.d_we = d_we;    assign bus1.d_we = d_we;
  assign bus0.d_addr = d_addr;  assign bus1.d_addr = d_addr;
  assign bus0.d_wdata = d_wdata;  assign bus1.d_wdata = d_wdata;
  assign bus0.i_req = i_req;  assign bus1.i_req = i_req;
  assign bus0.i_we = i_we;    assign bus1.i_we = i_we;
  assign bus0.i_addr = i_addr;  assign bus1.i_addr = i_addr;
  assign bus0.i_wdata = i_wdata;  assign bus1.i_wdata = i_wdata;
  assign bus0.mem_rd = mem_fn(bus0.mem_addr);
  assign bus1.mem_rd = mem_fn(bus1.mem_addr);

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  logic [1:0]    w_dack, w_iack, w_dstall, w_istall, w_en, w_we;
  logic [AW-1:0] w_addr [2];
  logic [DW-1:0] w_wd [2], w_drd [2], w_ird [2];
  assign w_dack   = {bus1.d_ack, bus0.d_ack};
  assign w_iack   = {bus1.i_ack, bus0.i_ack};
  assign w_dstall = {bus1.d_stall, bus0.d_stall};
  assign w_istall = {bus1.i_stall, bus0.i_stall};
  assign w_en     = {bus1.mem_en, bus0.mem_en};
  assign w_we     = {bus1.mem_we, bus0.mem_we};
  assign w_addr[0] = bus0.mem_addr;  assign w_addr[1] = bus1.mem_addr;
  assign w_wd[0]   = bus0.mem_wd;    assign w_wd[1]   = bus1.mem_wd;
  assign w_drd[0]  = bus0.d_rdata;   assign w_drd[1]  = bus1.d_rdata;
  assign w_ird[0]  = bus0.i_rdata;   assign w_ird[1]  = bus1.i_rdata;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each access is a grant timestamp; memory busy for lat cycles after it, ack the
  // cycle after that, next grant no earlier than lat+2 edges later.
  int            lat [2] = '{4, 1};
  int            g_e [2] = '{-1, -1};
  int            free_e [2] = '{0, 0};
  bit            who_e [2], we_e [2];
  bit            last_e [2] = '{1'b1, 1'b1};
  logic [AW-1:0] addr_e [2];
  logic [DW-1:0] wd_e [2];
  logic [DW-1:0] drd_e [2] = '{32'h0, 32'h0};
  logic [DW-1:0] ird_e [2] = '{32'h0, 32'h0};

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        g_e[k] = -1; free_e[k] = 0; last_e[k] = 1'b1; drd_e[k] = '0; ird_e[k] = '0;
      end else begin
        if (g_e[k] >= 0 && cyc == g_e[k] + lat[k] && !we_e[k]) begin
          if (who_e[k]) ird_e[k] = mem_fn(addr_e[k]);
          else          drd_e[k] = mem_fn(addr_e[k]);
        end
        if (cyc >= free_e[k] && (d_req || i_req)) begin
          who_e[k]  = (d_req && i_req) ? !last_e[k] : i_req;
          last_e[k] = who_e[k];
          we_e[k]   = who_e[k] ? i_we : d_we;
          addr_e[k] = who_e[k] ? i_addr : d_addr;
          wd_e[k]   = who_e[k] ? i_wdata : d_wdata;
          g_e[k]    = cyc;
          free_e[k] = cyc + lat[k] + 2;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        bit en, ack, dack, iack;
        en   = g_e[k] >= 0 && cyc >= g_e[k] && cyc < g_e[k] + lat[k];
        ack  = g_e[k] >= 0 && cyc == g_e[k] + lat[k];
        dack = ack && !who_e[k];
        iack = ack && who_e[k];
        check($sformatf("mem_en[%0d]", k), w_en[k], en);
        check($sformatf("d_ack[%0d]", k), w_dack[k], dack);
        check($sformatf("i_ack[%0d]", k), w_iack[k], iack);
        check($sformatf("d_stall[%0d]", k), w_dstall[k], d_req && !dack);
        check($sformatf("i_stall[%0d]", k), w_istall[k], i_req && !iack);
        check($sformatf("d_rdata[%0d]", k), w_drd[k], drd_e[k]);
        check($sformatf("i_rdata[%0d]", k), w_ird[k], ird_e[k]);
        if (en) begin
          check($sformatf("mem_we[%0d]", k), w_we[k], we_e[k]);
          check($sformatf("mem_addr[%0d]", k), w_addr[k], addr_e[k]);
          check($sformatf("mem_wd[%0d]", k), w_wd[k], wd_e[k]);
        end
      end
    end
  end

  // Cycles from the next edge until the chosen port acks on each DUT (n1 = LATENCY 1 DUT).
  task automatic wait_ack(input bit port, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #3;
      if (n1 == 0 && (port ? bus1.i_ack : bus1.d_ack)) n1 = t;
      if (port ? bus0.i_ack : bus0.d_ack) begin
        n0 = t;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout port=%0d actual=no_ack required=ack_within_40", port);
  endtask

  initial begin
    int n0, n1, nacks, last_cyc;
    reset_n = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_d_ack", bus0.d_ack, 0);
    check("rst_i_ack", bus0.i_ack, 0);
    check("rst_mem_en", bus0.mem_en, 0);
    check("rst_mem_we", bus0.mem_we, 0);
    check("rst_mem_addr", bus0.mem_addr, 0);
    check("rst_mem_wd", bus0.mem_wd, 0);
    check("rst_d_rdata", bus0.d_rdata, 0);
    check("rst_i_rdata", bus0.i_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_d_stall", bus0.d_stall, 1);
    @(posedge clk);
    for (int t = 1; t <= 5; t++) begin
      #3;
      check($sformatf("rst_seq_mem_en_c%0d", t), bus0.mem_en, (t <= 4) ? 1 : 0);
      check($sformatf("rst_seq_d_ack_c%0d", t), bus0.d_ack, (t == 5) ? 1 : 0);
      check($sformatf("rst_seq_d_stall_c%0d", t), bus0.d_stall, (t == 5) ? 0 : 1);
      if (t < 5) @(posedge clk);
    end
    @(negedge clk);
    d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Single read on port I.
    i_req = 1'b1; i_we = 1'b0; i_addr = 10'h010; i_wdata = $urandom;
    wait_ack(1'b1, n0, n1);
    check("read_latency", n0, 5);
    check("read_latency_lat1", n1, 2);
    check("read_i_rdata", bus0.i_rdata, 32'hDEADBEEF);
    check("read_d_ack", bus0.d_ack, 0);
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);

    // Single write on port D; inputs scrambled after the grant edge.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FC; d_wdata = 32'h12345678;
    @(posedge clk);
    for (int t = 1; t <= 4; t++) begin
      #3;
      check("wr_mem_en", bus0.mem_en, 1);
      check("wr_mem_we", bus0.mem_we, 1);
      check("wr_mem_addr", bus0.mem_addr, 10'h3FC);
      check("wr_mem_wd", bus0.mem_wd, 32'h12345678);
      @(negedge clk);
      d_addr = AW'($urandom); d_wdata = $urandom;
      @(posedge clk);
    end
    #3;
    check("wr_d_ack", bus0.d_ack, 1);
    check("wr_d_rdata_hold", bus0.d_rdata, mem_fn(10'h000));
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    repeat (4) @(negedge clk);

    // Conflict from reset: D first, then alternating, acks LATENCY+2 apart.
    reset_n = 1'b0;
    d_req = 1'b1; i_req = 1'b1; d_we = 1'b0; i_we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nacks = 0;
    last_cyc = 0;
    for (int t = 1; t <= 60 && nacks < 6; t++) begin
      @(posedge clk);
      #3;
      if (bus0.d_ack || bus0.i_ack) begin
        check($sformatf("conflict_order_%0d", nacks), bus0.i_ack, nacks % 2);
        check($sformatf("conflict_wait_stall_%0d", nacks),
              bus0.i_ack ? bus0.d_stall : bus0.i_stall, 1);
        if (nacks > 0) check($sformatf("conflict_gap_%0d", nacks), cyc - last_cyc, 6);
        last_cyc = cyc;
        nacks++;
      end
      @(negedge clk);
      d_addr = AW'($urandom); i_addr = AW'($urandom);
    end
    if (nacks < 6) begin
      checks++;
      failures++;
      $display("FAIL conflict_acks actual=%0d required=6", nacks);
    end
    d_req = 1'b0; i_req = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the second BUSY cycle of a read, then a fresh access.
    i_req = 1'b1; i_we = 1'b0; i_addr = 10'h055;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_mem_en", bus0.mem_en, 0);
    check("midrst_i_ack", bus0.i_ack, 0);
    check("midrst_i_stall", bus0.i_stall, 1);
    check("midrst_i_rdata", bus0.i_rdata, 0);
    check("midrst_mem_en_lat1", bus1.mem_en, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(1'b1, n0, n1);
    check("midrst_fresh_latency", n0, 5);
    check("midrst_fresh_latency_lat1", n1, 2);
    check("midrst_fresh_rdata", bus0.i_rdata, mem_fn(10'h055));
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic with occasional resets.
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 199) != 0);
      d_req   = ($urandom_range(0, 3) != 0);
      i_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1);
      i_we    = $urandom_range(0, 1);
      d_addr  = ($urandom_range(0, 7) == 0) ? 10'h010 : AW'($urandom);
      i_addr  = AW'($urandom);
      d_wdata = $urandom;
      i_wdata = $urandom;
    end
    @(negedge clk);
    reset_n = 1'b1; d_req = 1'b0; i_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
